apb_mailbox: RTL and testbench



---
 rtl/apb_mailbox_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/apb_mailbox.sv | 150 +++++++++++++++
 tb/tb_apb_mailbox.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mailbox_pkg.sv
// Shared constants for the APB mailbox: register indices (PADDR[4:2]),
// STATUS bit positions and the read-handshake FSM encoding.
package apb_mailbox_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_IRQ_EN = 3'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_COUNT = 8;
  localparam int ST_RX_COUNT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage, registered occupancy count and a
// combinational head; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so the storage itself needs no reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_mailbox.sv
// APB3 mailbox between the Cortex-M3 and fabric logic: TX FIFO (M3->fabric),
// RX FIFO (fabric->M3), STATUS, IRQ_EN and a registered level interrupt.
module apb_mailbox
  import apb_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] m2f_data,
  output logic        m2f_valid,
  input  logic        m2f_ready,
  input  logic [31:0] f2m_data,
  input  logic        f2m_valid,
  output logic        f2m_ready,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;

  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [2:0]    reg_sel;
  logic          wr_access;
  logic          wr_err;
  logic          tx_push;
  logic          rx_pop;
  logic          rd_err;
  logic [31:0]   rd_data;
  logic [31:0]   status;
  logic [31:0]   prdata_p1;
  logic          pslverr_p1;
  logic [1:0]    irq_en;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [31:0]   rx_head;
  logic          unused_paddr;

  assign reg_sel      = PADDR[4:2];
  assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

  // Writes complete in their first access cycle; reads never reach IDLE with PENABLE set.
  assign wr_access = PSEL & PENABLE & PWRITE & (state == IDLE);
  assign tx_push   = wr_access & (reg_sel == REG_TXDATA);
  assign wr_err    = wr_access & (reg_sel[2] | (tx_push & tx_full));
  assign rx_pop    = (state == RD_DONE) & (reg_sel == REG_RXDATA) & ~pslverr_p1;

  assign PREADY    = (state != RD_WAIT);
  assign PSLVERR   = pslverr_p1 | wr_err;
  assign PRDATA    = prdata_p1;
  assign m2f_valid = ~tx_empty;
  assign f2m_ready = ~rx_full;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .push      (tx_push),
    .push_data (PWDATA),
    .pop       (m2f_ready),
    .head      (m2f_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .push      (f2m_valid),
    .push_data (f2m_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    status = '0;
    status[ST_TX_FULL]          = tx_full;
    status[ST_TX_EMPTY]         = tx_empty;
    status[ST_RX_FULL]          = rx_full;
    status[ST_RX_EMPTY]         = rx_empty;
    status[ST_TX_COUNT +: CW]   = tx_count;
    status[ST_RX_COUNT +: CW]   = rx_count;
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (reg_sel)
      REG_TXDATA: rd_data = '0;
      REG_RXDATA: begin
        rd_err  = rx_empty;
        rd_data = rx_head;
      end
      REG_STATUS: rd_data = status;
      REG_IRQ_EN: rd_data = {30'b0, irq_en};
      default:    rd_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSEL && !PENABLE && !PWRITE) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- read response stage: captured in RD_WAIT, presented in RD_DONE ----
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      prdata_p1  <= '0;
      pslverr_p1 <= 1'b0;
    end else if (state == RD_WAIT) begin
      prdata_p1  <= rd_err ? '0 : rd_data;
      pslverr_p1 <= rd_err;
    end else begin
      prdata_p1  <= '0;
      pslverr_p1 <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_access && reg_sel == REG_IRQ_EN) irq_en <= PWDATA[1:0];
      irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end

endmodule

// File: tb/tb_apb_mailbox.sv
// Bench for apb_mailbox: register table, directed corner sequences and a
// randomized mix checked against a queue-based model of the mailbox.
module tb_apb_mailbox;
  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] m2f_data;
  logic        m2f_valid;
  logic        m2f_ready = 1'b0;
  logic [31:0] f2m_data = '0;
  logic        f2m_valid = 1'b0;
  logic        f2m_ready;
  logic        irq;

  always #5 PCLK = ~PCLK;

  apb_mailbox #(.DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .m2f_data(m2f_data),
    .m2f_valid(m2f_valid), .m2f_ready(m2f_ready), .f2m_data(f2m_data),
    .f2m_valid(f2m_valid), .f2m_ready(f2m_ready), .irq(irq)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [1:0]  en_m = 2'b00;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic pop_same,
                           output logic err, output logic rdy, output logic vld);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; m2f_ready = pop_same;
    #1;
    err = PSLVERR; rdy = PREADY; vld = m2f_valid;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; m2f_ready = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic err, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    waits = 0;
    while (!PREADY && waits < 4) begin
      @(posedge PCLK); #1;
      waits++;
    end
    data = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = '0;
    s[0] = (tx_q.size() == DEPTH);
    s[1] = (tx_q.size() == 0);
    s[2] = (rx_q.size() == DEPTH);
    s[3] = (rx_q.size() == 0);
    s[15:8]  = 8'(tx_q.size());
    s[23:16] = 8'(rx_q.size());
    return s;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    logic err, rdy, vld, exp_err;
    int off;
    off = int'(addr[4:2]);
    exp_err = (off >= 4) || (off == 0 && tx_q.size() == DEPTH);
    apb_write(addr, data, 1'b0, err, rdy, vld);
    chk("wr_pready", rdy, 1);
    chk("wr_pslverr", err, exp_err);
    if (off == 0 && !exp_err) tx_q.push_back(data);
    if (off == 3) en_m = data[1:0];
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic [31:0] data, exp;
    logic err, exp_err;
    int waits, off;
    off = int'(addr[4:2]);
    exp = '0; exp_err = 1'b0;
    case (off)
      0: exp = '0;
      1: if (rx_q.size() == 0) exp_err = 1'b1; else exp = rx_q.pop_front();
      2: exp = status_m();
      3: exp = {30'b0, en_m};
      default: exp_err = 1'b1;
    endcase
    apb_read(addr, data, err, waits);
    chk("rd_waits", waits, 1);
    chk("rd_prdata", data, exp);
    chk("rd_pslverr", err, exp_err);
  endtask

  task automatic fab_push(input logic [31:0] data);
    @(posedge PCLK); #1;
    chk("f2m_ready", f2m_ready, rx_q.size() < DEPTH);
    f2m_data = data; f2m_valid = 1'b1;
    @(posedge PCLK); #1;
    f2m_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(data);
  endtask

  task automatic fab_pop();
    @(posedge PCLK); #1;
    chk("m2f_valid", m2f_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("m2f_data", m2f_data, tx_q[0]);
    m2f_ready = 1'b1;
    @(posedge PCLK); #1;
    m2f_ready = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic settle();
    @(posedge PCLK); #1;
    chk("irq", irq, (en_m[0] && rx_q.size() != 0) || (en_m[1] && tx_q.size() == 0));
    chk("m2f_valid", m2f_valid, tx_q.size() != 0);
    chk("f2m_ready", f2m_ready, rx_q.size() < DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic e, r, v;
    int w, op;

    tbl[0]  = '{32'h0000_0008, 1'b0, 32'h0,         32'h0000_000A, 1'b0};
    tbl[1]  = '{32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[2]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[3]  = '{32'h0000_000C, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[4]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0000_0003, 1'b0};
    tbl[5]  = '{32'h0000_000C, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0};
    tbl[6]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[7]  = '{32'h0000_0014, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{32'h0000_001C, 1'b1, 32'h1111_2222, 32'h0,         1'b1};
    tbl[9]  = '{32'h0000_0010, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[10] = '{32'h0000_0008, 1'b1, 32'h0000_1234, 32'h0,         1'b0};
    tbl[11] = '{32'h0000_0004, 1'b1, 32'h0000_5555, 32'h0,         1'b0};
    tbl[12] = '{32'h0000_0004, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[13] = '{32'hFFFF_FFE8, 1'b0, 32'h0,         32'h0000_000A, 1'b0};
    tbl[14] = '{32'h0000_0014, 1'b1, 32'hABCD_0000, 32'h0,         1'b1};
    tbl[15] = '{32'h0000_0008, 1'b0, 32'h0,         32'h0000_000A, 1'b0};

    // Power-on reset
    repeat (3) @(posedge PCLK);
    #1;
    chk("por_pready", PREADY, 1);
    chk("por_prdata", PRDATA, 0);
    chk("por_pslverr", PSLVERR, 0);
    chk("por_m2f_valid", m2f_valid, 0);
    chk("por_m2f_data", m2f_data, 0);
    chk("por_f2m_ready", f2m_ready, 1);
    chk("por_irq", irq, 0);
    PRESETN = 1'b1;

    // Register table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].wdata, 1'b0, e, r, v);
        chk($sformatf("tbl%0d_pready", i), r, 1);
        chk($sformatf("tbl%0d_pslverr", i), e, tbl[i].exp_err);
        if (tbl[i].addr[4:2] == 3'd3) en_m = tbl[i].wdata[1:0];
      end else begin
        apb_read(tbl[i].addr, d, e, w);
        chk($sformatf("tbl%0d_waits", i), w, 1);
        chk($sformatf("tbl%0d_prdata", i), d, tbl[i].exp_rdata);
        chk($sformatf("tbl%0d_pslverr", i), e, tbl[i].exp_err);
      end
    end
    settle();

    // Reset in the middle of a read
    do_write(32'h0C, 32'h1);
    fab_push(32'hCAFE_0001);
    settle();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h04;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    chk("midrd_pready_low", PREADY, 0);
    PRESETN = 1'b0;
    #1;
    chk("rst_pready", PREADY, 1);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_irq", irq, 0);
    chk("rst_f2m_ready", f2m_ready, 1);
    chk("rst_m2f_valid", m2f_valid, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tx_q.delete(); rx_q.delete(); en_m = 2'b00;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    do_read(32'h08);

    // Single TX word: zero wait states, m2f_valid the cycle after
    apb_write(32'h00, 32'hDEAD_BEEF, 1'b0, e, r, v);
    chk("tx1_pready", r, 1);
    chk("tx1_pslverr", e, 0);
    chk("tx1_valid_in_access", v, 0);
    chk("tx1_valid_next", m2f_valid, 1);
    chk("tx1_data_next", m2f_data, 32'hDEAD_BEEF);
    tx_q.push_back(32'hDEAD_BEEF);
    do_read(32'h08);
    fab_pop();
    settle();

    // Fill TX, overflow write, drain in order
    for (int i = 0; i < DEPTH; i++) do_write(32'h00, 32'hA000_0000 + i);
    do_write(32'h00, 32'h99);
    do_read(32'h08);
    for (int i = 0; i < DEPTH; i++) fab_pop();
    settle();

    // RX word then an underflow read
    fab_push(32'h1234_5678);
    do_read(32'h04);
    do_read(32'h04);
    settle();

    // Interrupt timing
    do_write(32'h0C, 32'h1);
    fab_push(32'h0000_0055);
    chk("irq_before", irq, 0);
    @(posedge PCLK); #1;
    chk("irq_after_push", irq, 1);
    do_read(32'h04);
    chk("irq_at_rd_done_edge", irq, 1);
    @(posedge PCLK); #1;
    chk("irq_after_pop", irq, 0);
    do_write(32'h0C, 32'h2);
    settle();
    do_write(32'h0C, 32'h0);
    settle();

    // Write to full TX while the fabric pops in the same cycle
    for (int i = 0; i < DEPTH; i++) do_write(32'h00, 32'hB000_0000 + i);
    apb_write(32'h00, 32'h77, 1'b1, e, r, v);
    chk("fullpop_pslverr", e, 1);
    void'(tx_q.pop_front());
    do_read(32'h08);
    while (tx_q.size() != 0) fab_pop();
    settle();

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      a = $urandom();
      a[1:0] = 2'b00;
      case (op)
        0, 1: begin a[4:2] = 3'd0; do_write(a, $urandom()); end
        2:    begin a[4:2] = 3'd1; do_read(a); end
        3:    begin a[4:2] = 3'd2; do_read(a); end
        4:    fab_push($urandom());
        5:    fab_pop();
        6:    begin a[4:2] = 3'd3; do_write(a, $urandom()); end
        default: begin
          a[4:2] = 3'(4 + $urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) do_write(a, $urandom()); else do_read(a);
        end
      endcase
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
